// File: rtl/int_pending_capture_if.sv
// Port-count package plus the bundled interrupt/config/ack/pending bus of int_pending_capture.
// master = arbiter/CPU side driving lines, config and acks; slave = the capture block.
package InterruptArbiterPkg;
   localparam int NUM_INT_PORTS = 16;
endpackage

interface int_pending_capture_if #(
   parameter int NUM_INT_PORTS = InterruptArbiterPkg::NUM_INT_PORTS,
   parameter int ID_W          = $clog2(NUM_INT_PORTS)
);
   logic [NUM_INT_PORTS-1:0] irq_i;
   logic                     cfg_we;
   logic [1:0]               cfg_addr;
   logic [NUM_INT_PORTS-1:0] cfg_wdata;
   logic [NUM_INT_PORTS-1:0] cfg_rdata;
   logic                     ack_vld_i;
   logic [ID_W-1:0]          ack_id_i;
   logic [NUM_INT_PORTS-1:0] pend_o;
   logic                     pend_any_o;
   logic [NUM_INT_PORTS-1:0] ovf_o;

   modport master (
      output irq_i, cfg_we, cfg_addr, cfg_wdata, ack_vld_i, ack_id_i,
      input  cfg_rdata, pend_o, pend_any_o, ovf_o
   );
   modport slave (
      input  irq_i, cfg_we, cfg_addr, cfg_wdata, ack_vld_i, ack_id_i,
      output cfg_rdata, pend_o, pend_any_o, ovf_o
   );
endinterface

// File: rtl/int_pending_capture.sv
// Per-port interrupt conditioning into a registered pending vector; 1-cycle latency, no backpressure.
// INT_EDGE_MODE_EN builds edge-latched mode with ack clear and sticky overflow; otherwise level-only.
module int_pending_capture #(
   parameter int NUM_INT_PORTS = InterruptArbiterPkg::NUM_INT_PORTS,
   parameter int ID_W          = $clog2(NUM_INT_PORTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   int_pending_capture_if.slave  bus
);
   localparam logic [1:0] A_EN   = 2'd0;
   localparam logic [1:0] A_MODE = 2'd1;
   localparam logic [1:0] A_OVF  = 2'd2;

   logic [NUM_INT_PORTS-1:0] r_en;
   logic [NUM_INT_PORTS-1:0] r_pend;
   logic [NUM_INT_PORTS-1:0] w_pend_nxt;
   logic [NUM_INT_PORTS-1:0] w_mode;
   logic [NUM_INT_PORTS-1:0] w_ovf;

`ifdef INT_EDGE_MODE_EN
   logic [NUM_INT_PORTS-1:0] r_mode;
   logic [NUM_INT_PORTS-1:0] r_ovf;
   logic [NUM_INT_PORTS-1:0] r_irq_q;
   logic [NUM_INT_PORTS-1:0] w_rise;
   logic [NUM_INT_PORTS-1:0] w_ack_hit;
   logic [NUM_INT_PORTS-1:0] w_ovf_set;
   logic [NUM_INT_PORTS-1:0] w_ovf_clr;

   assign w_rise    = bus.irq_i & ~r_irq_q;
   assign w_ovf_clr = (bus.cfg_we && bus.cfg_addr == A_OVF) ? bus.cfg_wdata : '0;

   // Out-of-range ack IDs never match any port index and fall out naturally.
   always_comb begin
      w_ack_hit = '0;
      for (int i = 0; i < NUM_INT_PORTS; i++) begin
         w_ack_hit[i] = bus.ack_vld_i && (bus.ack_id_i == ID_W'(i));
      end
   end

   // A new edge beats a same-cycle ack, and in that case it is not an overflow.
   always_comb begin
      w_pend_nxt = '0;
      w_ovf_set  = '0;
      for (int i = 0; i < NUM_INT_PORTS; i++) begin
         if (r_en[i]) begin
            if (r_mode[i]) begin
               w_pend_nxt[i] = w_rise[i] | (r_pend[i] & ~w_ack_hit[i]);
               w_ovf_set[i]  = w_rise[i] & r_pend[i] & ~w_ack_hit[i];
            end else begin
               w_pend_nxt[i] = bus.irq_i[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mode  <= '0;
         r_ovf   <= '0;
         r_irq_q <= '0;
      end else begin
         r_irq_q <= bus.irq_i;
         r_ovf   <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
         if (bus.cfg_we && bus.cfg_addr == A_MODE) begin
            r_mode <= bus.cfg_wdata;
         end
      end
   end

   assign w_mode = r_mode;
   assign w_ovf  = r_ovf;
`else
   logic w_unused_ack;

   assign w_pend_nxt   = r_en & bus.irq_i;
   assign w_mode       = '0;
   assign w_ovf        = '0;
   assign w_unused_ack = ^{bus.ack_vld_i, bus.ack_id_i};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_en   <= '0;
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         if (bus.cfg_we && bus.cfg_addr == A_EN) begin
            r_en <= bus.cfg_wdata;
         end
      end
   end

   always_comb begin
      case (bus.cfg_addr)
         A_EN:    bus.cfg_rdata = r_en;
         A_MODE:  bus.cfg_rdata = w_mode;
         A_OVF:   bus.cfg_rdata = w_ovf;
         default: bus.cfg_rdata = '0;
      endcase
   end

   assign bus.pend_o     = r_pend;
   assign bus.pend_any_o = |r_pend;
   assign bus.ovf_o      = w_ovf;
endmodule

// File: tb/tb_int_pending_capture.sv
// Directed plus randomized bench for int_pending_capture against a per-port behavioural model.
module tb_int_pending_capture;
   localparam int N  = 16;
   localparam int IW = 4;
`ifdef INT_EDGE_MODE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   int_pending_capture_if #(.NUM_INT_PORTS(N), .ID_W(IW)) ifc ();

   int_pending_capture #(.NUM_INT_PORTS(N), .ID_W(IW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   bit m_en [N];
   bit m_mode [N];
   bit m_ovf [N];
   bit m_pend [N];
   bit m_irqq [N];

   function automatic logic [N-1:0] pk(input bit a [N]);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = a[i];
      return r;
   endfunction

   function automatic logic [N-1:0] exp_rdata();
      case (ifc.cfg_addr)
         2'd0:    return pk(m_en);
         2'd1:    return EDGE ? pk(m_mode) : '0;
         2'd2:    return EDGE ? pk(m_ovf) : '0;
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Applies one clock edge of the reference rules to the model.
   task automatic model_edge();
      bit np [N];
      bit rise, ack, wr;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_mode[i] = 0; m_ovf[i] = 0; m_pend[i] = 0; m_irqq[i] = 0;
         end
         return;
      end
      for (int i = 0; i < N; i++) begin
         rise = ifc.irq_i[i] && !m_irqq[i];
         ack  = ifc.ack_vld_i && (int'(ifc.ack_id_i) == i);
         np[i] = 0;
         if (m_en[i] && EDGE && m_mode[i]) begin
            if (rise) begin
               if (m_pend[i] && !ack) m_ovf[i] = 1;
               np[i] = 1;
            end else begin
               np[i] = m_pend[i] && !ack;
            end
         end else if (m_en[i]) begin
            np[i] = ifc.irq_i[i];
         end
      end
      for (int i = 0; i < N; i++) begin
         wr = ifc.cfg_we && ifc.cfg_wdata[i];
         if (EDGE && ifc.cfg_we && ifc.cfg_addr == 2'd2 && wr) begin
            rise = ifc.irq_i[i] && !m_irqq[i];
            ack  = ifc.ack_vld_i && (int'(ifc.ack_id_i) == i);
            if (!(m_en[i] && m_mode[i] && rise && m_pend[i] && !ack)) m_ovf[i] = 0;
         end
         if (ifc.cfg_we && ifc.cfg_addr == 2'd0) m_en[i] = ifc.cfg_wdata[i];
         if (EDGE && ifc.cfg_we && ifc.cfg_addr == 2'd1) m_mode[i] = ifc.cfg_wdata[i];
         m_pend[i] = np[i];
         m_irqq[i] = ifc.irq_i[i];
      end
   endtask

   task automatic cycle(input string tag);
      #1;
      chk({tag, "/rdata"}, ifc.cfg_rdata, exp_rdata());
      model_edge();
      @(posedge clk);
      #1;
      chk({tag, "/pend"}, ifc.pend_o, pk(m_pend));
      chk({tag, "/any"}, {{(N-1){1'b0}}, ifc.pend_any_o}, {{(N-1){1'b0}}, |pk(m_pend)});
      chk({tag, "/ovf"}, ifc.ovf_o, EDGE ? pk(m_ovf) : '0);
   endtask

   task automatic idle();
      ifc.cfg_we = 1'b0; ifc.cfg_addr = 2'd0; ifc.cfg_wdata = '0;
      ifc.ack_vld_i = 1'b0; ifc.ack_id_i = '0;
   endtask

   task automatic wr_cfg(input logic [1:0] a, input logic [N-1:0] d, input string tag);
      ifc.cfg_we = 1'b1; ifc.cfg_addr = a; ifc.cfg_wdata = d;
      cycle(tag);
      idle();
   endtask

   initial begin
      logic [N-1:0] rnd;
      idle();
      ifc.irq_i = '1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      cycle("rst0");
      cycle("rst1");
      chk("rst_pend_const", ifc.pend_o, '0);
      chk("rst_ovf_const", ifc.ovf_o, '0);
      chk("rst_any_const", {{(N-1){1'b0}}, ifc.pend_any_o}, '0);

      rst_n = 1'b1; ifc.irq_i = '0;
      cycle("idle");
      wr_cfg(2'd0, 16'h0001, "en0");
      ifc.irq_i = 16'h0001;
      cycle("lvl_hi1");
      chk("lvl_first_const", ifc.pend_o, 16'h0001);
      ifc.ack_vld_i = 1'b1; ifc.ack_id_i = 4'd0;
      cycle("lvl_hi2_ack");
      chk("lvl_ack_ignored", ifc.pend_o, 16'h0001);
      idle();
      cycle("lvl_hi3");
      ifc.irq_i = '0;
      cycle("lvl_lo");
      chk("lvl_drop_const", ifc.pend_o, '0);

`ifdef INT_EDGE_MODE_EN
      wr_cfg(2'd0, 16'h0028, "en35");
      wr_cfg(2'd1, 16'h0028, "mode35");
      ifc.irq_i = 16'h0008; cycle("p3_pulse");
      ifc.irq_i = '0;       cycle("p3_hold1");
      cycle("p3_hold2");
      chk("p3_latched", ifc.pend_o, 16'h0008);
      ifc.irq_i = 16'h0008; cycle("p3_pulse2");
      ifc.irq_i = '0;       cycle("p3_after2");
      chk("p3_ovf", ifc.ovf_o, 16'h0008);
      ifc.ack_vld_i = 1'b1; ifc.ack_id_i = 4'd3; cycle("p3_ack");
      idle();
      chk("p3_cleared", ifc.pend_o, '0);
      wr_cfg(2'd2, 16'h0008, "ovf_w1c");
      chk("p3_ovf_clr", ifc.ovf_o, '0);
      ifc.irq_i = 16'h0020; cycle("p5_pulse");
      ifc.irq_i = '0;       cycle("p5_lo");
      ifc.irq_i = 16'h0020; ifc.ack_vld_i = 1'b1; ifc.ack_id_i = 4'd5;
      cycle("p5_rise_ack");
      idle();
      chk("p5_pend_kept", ifc.pend_o, 16'h0020);
      chk("p5_no_ovf", ifc.ovf_o, '0);
      ifc.irq_i = '0;
`endif

      wr_cfg(2'd0, '1, "en_all");
      ifc.irq_i = 16'hA5C3; cycle("pre_rst");
      rst_n = 1'b0; cycle("mid_rst");
      chk("mid_rst_pend", ifc.pend_o, '0);
      chk("mid_rst_ovf", ifc.ovf_o, '0);
      rst_n = 1'b1;

      for (int n = 0; n < 800; n++) begin
         rnd = N'($urandom);
         ifc.irq_i     = ifc.irq_i ^ (rnd & N'($urandom));
         ifc.cfg_we    = ($urandom_range(0, 5) == 0);
         ifc.cfg_addr  = 2'($urandom_range(0, 3));
         ifc.cfg_wdata = N'($urandom);
         ifc.ack_vld_i = ($urandom_range(0, 1) == 1);
         ifc.ack_id_i  = IW'($urandom_range(0, N - 1));
         rst_n         = ($urandom_range(0, 149) != 0);
         cycle("rand");
      end
      idle();
      rst_n = 1'b1;

      wr_cfg(2'd1, '1, "mode_all");
      ifc.cfg_addr = 2'd1;
      #1;
      chk("mode_readback", ifc.cfg_rdata, EDGE ? 16'hFFFF : 16'h0000);
      wr_cfg(2'd0, '1, "en_all2");
      ifc.irq_i = 16'h00FF; cycle("fin_hi");
      ifc.irq_i = '0;       cycle("fin_lo");
      ifc.cfg_addr = 2'd3;  cycle("rsvd_read");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/int_pending_capture.md
# int_pending_capture

Upstream front end of the interrupt arbiter: conditions the `NUM_INT_PORTS` raw interrupt lines into a registered per-port pending vector that the arbiter consumes.
- Each port is programmable as enabled or disabled, and as level- or edge-sensitive.
- Edge-mode requests are latched until the arbiter acknowledges them.
- A sticky per-port overflow flag records edges lost while a request was already pending.

## Interface
Parameters:
- `NUM_INT_PORTS`, default `InterruptArbiterPkg::NUM_INT_PORTS` (16): number of interrupt ports.
- `ID_W`, default `$clog2(NUM_INT_PORTS)` (4): width of the acknowledge port ID.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `irq_i`  in  NUM_INT_PORTS  raw interrupt lines, already synchronous to `clk`.
- `cfg_we`  in  1  config write strobe.
- `cfg_addr`  in  2  register select: 0 = ENABLE, 1 = MODE (1 = edge), 2 = OVF (write-1-to-clear), 3 = reserved.
- `cfg_wdata`  in  NUM_INT_PORTS  config write data.
- `cfg_rdata`  out  NUM_INT_PORTS  combinational read of the register selected by `cfg_addr`; reads 0 for address 3.
- `ack_vld_i`  in  1  arbiter acknowledges a serviced request.
- `ack_id_i`  in  ID_W  index of the acknowledged port.
- `pend_o`  out  NUM_INT_PORTS  registered pending vector to the arbiter.
- `pend_any_o`  out  1  OR-reduction of `pend_o`.
- `ovf_o`  out  NUM_INT_PORTS  sticky overflow flags.

## Operation
- Reset (`rst_n` = 0 at a clock edge):
  - clears `en`, `mode`, `ovf`, `pend` and `irq_q` (the registered copy of `irq_i`).
  - `pend_o`, `pend_any_o`, `ovf_o` and `cfg_rdata` are all 0 from the first cycle after reset.
  - Reset mid-operation discards pending requests and configuration.
- Rising-edge detect: `rise[i] = irq_i[i] & ~irq_q[i]`. `irq_q` updates every cycle regardless of `en`.
- Level port (`en[i]=1`, `mode[i]=0`):
  - next `pend[i] = irq_i[i]`.
  - Acknowledge is ignored; the request drops only when the source deasserts.
- Edge port (`en[i]=1`, `mode[i]=1`):
  - Set: `rise[i]`.
  - Clear: `ack_vld_i && ack_id_i==i`.
  - Priority: set wins over clear. An edge coinciding with the ack of the same port leaves `pend[i]=1` and does not set `ovf`.
  - `rise[i]` while `pend[i]=1` and not being cleared sets `ovf[i]`.
- Disabled port (`en[i]=0`): next `pend[i]=0`, edges are ignored, `ovf[i]` holds its value.
- Config writes take effect at the write edge:
  - ENABLE and MODE load `cfg_wdata`.
  - OVF clears the bits written as 1. A same-cycle overflow set wins over the clear.
  - Pending next-state in the write cycle uses the old `en`/`mode`.
  - Writing `mode[i]` from 1 to 0 makes the port level-sensitive from the next cycle; the latched pending bit is replaced by the line level.
- `ack_id_i >= NUM_INT_PORTS` is ignored. An ack on a non-pending port is a no-op.

## Timing
- Latency is 1 cycle: `irq_i` change at edge t appears on `pend_o` after edge t.
- Clear latency is 1 cycle: an ack sampled at edge t drops `pend_o` after edge t.
- An edge-mode pulse of a single cycle is captured.
- Back-to-back acks on different ports in consecutive cycles are supported.
- `pend_any_o` is derived from registered `pend`, with no extra cycle.
- `cfg_rdata` has zero latency and reflects register state before the current edge.

## Configuration
Macro `INT_EDGE_MODE_EN`.

Defined:
- Behaviour is as described above.

Undefined:
- No MODE or OVF storage is built and every port is level-sensitive.
- MODE and OVF read as 0, and writes to them are ignored.
- `ovf_o` is tied to 0.
- `ack_vld_i`/`ack_id_i` are unused.

## Test plan
- Reset with `irq_i`=16'hFFFF, `en` still 0 → `pend_o`=0, `ovf_o`=0, `pend_any_o`=0.
- ENABLE=16'h0001, MODE=0, drive `irq_i[0]` high for 3 cycles → `pend_o[0]`=1 for exactly 3 cycles, lagging by 1 cycle; an ack with id 0 has no effect.
- ENABLE=MODE=16'h0008, 1-cycle pulse on `irq_i[3]` → `pend_o[3]` stays 1 until ack with id 3, and clears the cycle after the ack.
- Port 3 edge-pending, second pulse on `irq_i[3]` (after deassert) → `ovf_o[3]`=1. OVF write 16'h0008 → `ovf_o[3]`=0.
- Port 5 edge-pending, new rising edge in the same cycle as ack with id 5 → `pend_o[5]` stays 1, `ovf_o[5]` stays 0.
- Assert reset mid-run with ports pending → all outputs 0 next cycle. With `INT_EDGE_MODE_EN` undefined, MODE write 16'hFFFF reads back 0 and all ports act as level-sensitive.
